mem_stage: RTL

//  Memory-access stage of the pipelined CPU, directly upstream of the writeback stage.
//  - Registers execute results; performs loads/stores against data memory via a req/ack handshake.
//  - Presents PC, ALU result, load data and MemRead to writeback through its own output register (MEM/WB).
//  - Stalls upstream while a memory access is outstanding.

---
 rtl/mem_stage_pkg.sv | 21 ++
 rtl/mem_stage_if.sv | 25 ++
 rtl/mem_stage_dmem_req_fsm.sv | 85 ++++++++
 rtl/mem_stage.sv | 96 +++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage: handshake state and the MEM/WB record
// that the writeback stage consumes.
package mem_stage_pkg;

  localparam int PC_W   = 16;
  localparam int DATA_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  typedef struct packed {
    logic [PC_W-1:0]   PC;
    logic [DATA_W-1:0] ALURes;
    logic [DATA_W-1:0] MemReadData;
    logic              MemRead;
    logic              Fault;
  } mem_wb_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/ack bus between the memory stage (master) and data memory (slave).
interface mem_stage_if
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 16
);

  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );

endinterface

// File: rtl/mem_stage_dmem_req_fsm.sv
// Request/ack handshake engine: holds the access registers stable while in REQ.
// Optional abort on a missing ack is enabled with MEM_TIMEOUT_EN.
module dmem_req_fsm
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              startWe,
  input  logic [ADDR_W-1:0] startAddr,
  input  logic [DATA_W-1:0] startWdata,
  mem_stage_if.master       bus,
  output logic              busy,
  output logic              done,
  output logic              timedOut
);

  state_t            stateReg;
  logic              weReg;
  logic [ADDR_W-1:0] addrReg;
  logic [DATA_W-1:0] wdataReg;
  logic              expire;

  // Request follows the state register, so an async reset drops it at once.
  assign bus.dmem_req   = (stateReg == REQ);
  assign bus.dmem_we    = weReg;
  assign bus.dmem_addr  = addrReg;
  assign bus.dmem_wdata = wdataReg;

  assign busy     = (stateReg == REQ);
  assign done     = (stateReg == REQ) && bus.dmem_ack;
  assign timedOut = expire;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] countReg;

  // An ack arriving in the expiry cycle still completes the access.
  assign expire = (stateReg == REQ) && !bus.dmem_ack &&
                  (countReg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg <= IDLE;
      weReg    <= 1'b0;
      addrReg  <= '0;
      wdataReg <= '0;
`ifdef MEM_TIMEOUT_EN
      countReg <= '0;
`endif
    end else begin
      case (stateReg)
        IDLE: begin
          if (start) begin
            stateReg <= REQ;
            weReg    <= startWe;
            addrReg  <= startAddr;
            wdataReg <= startWdata;
`ifdef MEM_TIMEOUT_EN
            countReg <= '0;
`endif
          end
        end
        REQ: begin
          if (bus.dmem_ack || expire) begin
            stateReg <= IDLE;
          end
`ifdef MEM_TIMEOUT_EN
          else begin
            countReg <= countReg + 1'b1;
          end
`endif
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: latches execute results, runs loads/stores through dmem_req_fsm
// and presents the MEM/WB register. MEM_TIMEOUT_EN enables abort with MemFault.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   PC,
  input  logic [DATA_W-1:0] ALURes,
  input  logic [DATA_W-1:0] StoreData,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              ValidIn,
  output logic              Stall,
  mem_stage_if.master       dmem,
  output logic              ValidOut,
  output logic [PC_W-1:0]   PCOut,
  output logic [DATA_W-1:0] ALUResOut,
  output logic [DATA_W-1:0] MemReadDataOut,
  output logic              MemReadOut,
  output logic              MemFault
);

  logic busy;
  logic done;
  logic timedOut;
  logic accept;
  logic memOp;

  logic [PC_W-1:0]   pcReg;
  logic [DATA_W-1:0] aluResReg;
  logic              memReadReg;
  mem_wb_t           wbReg;
  logic              validReg;

  assign accept = ValidIn && !busy;
  assign memOp  = MemRead || MemWrite;
  assign Stall  = busy;

  dmem_req_fsm #(
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_fsm (
    .clk        (clk),
    .rst        (rst),
    .start      (accept && memOp),
    .startWe    (MemWrite),
    .startAddr  (ALURes[ADDR_W-1:0]),
    .startWdata (StoreData),
    .bus        (dmem),
    .busy       (busy),
    .done       (done),
    .timedOut   (timedOut)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcReg      <= '0;
      aluResReg  <= '0;
      memReadReg <= 1'b0;
      wbReg      <= '0;
      validReg   <= 1'b0;
    end else begin
      validReg <= 1'b0;
      if (accept && memOp) begin
        pcReg      <= PC;
        aluResReg  <= ALURes;
        // A combined read+write is carried out as a plain store.
        memReadReg <= MemRead && !MemWrite;
      end
      if (accept && !memOp) begin
        wbReg    <= '{PC: PC, ALURes: ALURes, MemReadData: '0, MemRead: 1'b0, Fault: 1'b0};
        validReg <= 1'b1;
      end else if (done) begin
        wbReg    <= '{PC: pcReg, ALURes: aluResReg,
                      MemReadData: memReadReg ? dmem.dmem_rdata : '0,
                      MemRead: memReadReg, Fault: 1'b0};
        validReg <= 1'b1;
      end else if (timedOut) begin
        wbReg    <= '{PC: pcReg, ALURes: aluResReg, MemReadData: '0, MemRead: 1'b0, Fault: 1'b1};
        validReg <= 1'b1;
      end
    end
  end

  assign ValidOut       = validReg;
  assign PCOut          = wbReg.PC;
  assign ALUResOut      = wbReg.ALURes;
  assign MemReadDataOut = wbReg.MemReadData;
  assign MemReadOut     = wbReg.MemRead;
  assign MemFault       = wbReg.Fault;

endmodule
